// File: rtl/sequence_builder.sv
// Genius colour sequence builder: turns LFSR words into one-hot colours and
// appends them to a small memory. Runs of three equal colours are rejected.
module sequence_builder #(
  parameter int DEPTH     = 16,
  parameter int ADDR_W    = 4,
  parameter int MAX_RETRY = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [3:0]        rnd,
  input  logic              clear,
  input  logic              append,
  output logic              busy,
  output logic              append_done,
  output logic              overflow,
  output logic [ADDR_W:0]   length,
  output logic              full,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [3:0]        rd_data
);

  localparam int RETRY_W = $clog2(MAX_RETRY + 1);

  typedef enum logic [1:0] {IDLE, SAMPLE, DONE} state_t;

  state_t             state;
  logic [3:0]         mem [DEPTH];
  logic [1:0]         last_idx;
  logic [1:0]         run_cnt;
  logic [RETRY_W-1:0] retry_cnt;

  logic [1:0] cand_idx;
  logic [1:0] wr_idx;
  logic [1:0] next_run;
  logic       reject;
  logic       force_sub;
  logic       wr_en;

  function automatic logic [3:0] onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  assign full = (length == (ADDR_W+1)'(DEPTH));

  // Candidate evaluation; the substitute colour always differs from the last one.
  always_comb begin
    cand_idx  = rnd[1:0];
    reject    = (length >= (ADDR_W+1)'(2)) && (run_cnt == 2'd2) && (cand_idx == last_idx);
    force_sub = (retry_cnt == RETRY_W'(MAX_RETRY));
    wr_idx    = force_sub ? (last_idx + 2'd1) : cand_idx;
    wr_en     = (state == SAMPLE) && !clear && (force_sub || !reject);
    next_run  = ((length != '0) && (wr_idx == last_idx)) ? 2'd2 : 2'd1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      length      <= '0;
      busy        <= 1'b0;
      append_done <= 1'b0;
      overflow    <= 1'b0;
      retry_cnt   <= '0;
      run_cnt     <= '0;
      last_idx    <= '0;
    end else begin
      append_done <= 1'b0;
      overflow    <= 1'b0;
      if (clear) begin
        state     <= IDLE;
        length    <= '0;
        run_cnt   <= '0;
        retry_cnt <= '0;
        busy      <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (append && full) begin
              overflow <= 1'b1;
            end else if (append) begin
              state <= SAMPLE;
              busy  <= 1'b1;
            end
          end
          SAMPLE: begin
            if (wr_en) begin
              length      <= length + 1'b1;
              last_idx    <= wr_idx;
              run_cnt     <= next_run;
              append_done <= 1'b1;
              state       <= DONE;
            end else begin
              retry_cnt <= retry_cnt + 1'b1;
            end
          end
          DONE: begin
            retry_cnt <= '0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Sequence storage carries no reset; entries beyond length are masked on read.
  always_ff @(posedge clock) begin
    if (wr_en) mem[length[ADDR_W-1:0]] <= onehot(wr_idx);
  end

  // Read stage: compares against length as it stood before this edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) rd_data <= 4'b0000;
    else        rd_data <= ({1'b0, rd_addr} < length) ? mem[rd_addr] : 4'b0000;
  end

endmodule

// File: tb/tb_sequence_builder.sv
// Directed bench for sequence_builder: a vector table for plain appends and
// readback, plus hand sequences for rejection, substitution, full, clear, reset.
module tb_sequence_builder;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] rnd;
  logic       clear;
  logic       append;
  logic       busy;
  logic       append_done;
  logic       overflow;
  logic [4:0] length;
  logic       full;
  logic [3:0] rd_addr;
  logic [3:0] rd_data;

  int n_cmp = 0;
  int n_bad = 0;

  sequence_builder #(.DEPTH(16), .ADDR_W(4), .MAX_RETRY(8)) dut (
    .clock(clock), .reset(reset), .rnd(rnd), .clear(clear), .append(append),
    .busy(busy), .append_done(append_done), .overflow(overflow),
    .length(length), .full(full), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] rnd;
    logic       append;
    logic [3:0] rd_addr;
    logic       exp_busy;
    logic       exp_done;
    logic [4:0] exp_len;
    logic [3:0] exp_rd;
  } vec_t;

  vec_t vecs[10];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic app_ok(input logic [3:0] r, input int exp_len);
    rnd = r; append = 1'b1;
    tick();
    chk("app_busy", busy, 1);
    append = 1'b0;
    tick();
    chk("app_done", append_done, 1);
    chk("app_len", length, exp_len);
    tick();
    chk("app_done_clr", append_done, 0);
    chk("app_idle", busy, 0);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clear_len", length, 0);
    chk("clear_busy", busy, 0);
  endtask

  initial begin
    // rnd, append, rd_addr, busy, done, len, rd
    vecs[0] = '{4'h2, 1'b1, 4'd0, 1'b1, 1'b0, 5'd0, 4'b0000};
    vecs[1] = '{4'h2, 1'b0, 4'd0, 1'b1, 1'b1, 5'd1, 4'b0000};
    vecs[2] = '{4'h2, 1'b0, 4'd0, 1'b0, 1'b0, 5'd1, 4'b0100};
    vecs[3] = '{4'h7, 1'b1, 4'd0, 1'b1, 1'b0, 5'd1, 4'b0100};
    vecs[4] = '{4'h7, 1'b0, 4'd0, 1'b1, 1'b1, 5'd2, 4'b0100};
    vecs[5] = '{4'h7, 1'b0, 4'd1, 1'b0, 1'b0, 5'd2, 4'b1000};
    vecs[6] = '{4'hC, 1'b1, 4'd1, 1'b1, 1'b0, 5'd2, 4'b1000};
    vecs[7] = '{4'hC, 1'b0, 4'd2, 1'b1, 1'b1, 5'd3, 4'b0000};
    vecs[8] = '{4'hC, 1'b0, 4'd2, 1'b0, 1'b0, 5'd3, 4'b0001};
    vecs[9] = '{4'hC, 1'b0, 4'd3, 1'b0, 1'b0, 5'd3, 4'b0000};

    reset = 1'b0; rnd = 4'h0; clear = 1'b0; append = 1'b0; rd_addr = 4'd0;
    tick(); tick();
    chk("rst_len", length, 0);
    chk("rst_full", full, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rd", rd_data, 0);
    reset = 1'b1;
    tick();
    chk("post_rst_rd0", rd_data, 0);
    chk("post_rst_done", append_done, 0);

    for (int i = 0; i < 10; i++) begin
      rnd = vecs[i].rnd; append = vecs[i].append; rd_addr = vecs[i].rd_addr;
      tick();
      chk($sformatf("v%0d_busy", i), busy, vecs[i].exp_busy);
      chk($sformatf("v%0d_done", i), append_done, vecs[i].exp_done);
      chk($sformatf("v%0d_len", i), length, vecs[i].exp_len);
      chk($sformatf("v%0d_rd", i), rd_data, vecs[i].exp_rd);
      chk($sformatf("v%0d_ovf", i), overflow, 0);
    end
    append = 1'b0;

    // Repeat rejection: two 0010 entries, then three rejected samples of idx 1.
    do_clear();
    app_ok(4'h1, 1);
    app_ok(4'h1, 2);
    rnd = 4'h1; append = 1'b1;
    tick();
    append = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rej_busy", busy, 1);
      chk("rej_nodone", append_done, 0);
      chk("rej_len", length, 2);
    end
    rnd = 4'h0;
    tick();
    chk("rej_done", append_done, 1);
    chk("rej_len3", length, 3);
    tick();
    rd_addr = 4'd2; tick();
    chk("rej_rd2", rd_data, 4'b0001);
    rd_addr = 4'd1; tick();
    chk("rej_rd1", rd_data, 4'b0010);

    // Forced substitute after MAX_RETRY rejections of 1000.
    do_clear();
    app_ok(4'h3, 1);
    app_ok(4'h3, 2);
    rnd = 4'h3; append = 1'b1;
    tick();
    append = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("sub_wait_busy", busy, 1);
      chk("sub_wait_nodone", append_done, 0);
    end
    tick();
    chk("sub_done", append_done, 1);
    chk("sub_len", length, 3);
    tick();
    rd_addr = 4'd2; tick();
    chk("sub_rd2", rd_data, 4'b0001);

    // Fill to DEPTH with alternating colours, then overflow.
    for (int i = 1; i <= 13; i++) app_ok(4'(i), 3 + i);
    chk("full_flag", full, 1);
    chk("full_len", length, 16);
    rd_addr = 4'd15; tick();
    chk("full_rd15", rd_data, 4'b0010);
    rnd = 4'h2; append = 1'b1;
    tick();
    append = 1'b0;
    chk("ovf_pulse", overflow, 1);
    chk("ovf_busy", busy, 0);
    chk("ovf_len", length, 16);
    tick();
    chk("ovf_clr", overflow, 0);
    chk("ovf_nodone", append_done, 0);
    chk("ovf_len2", length, 16);

    // Clear while stuck resampling.
    do_clear();
    app_ok(4'h1, 1);
    app_ok(4'h1, 2);
    rnd = 4'h1; append = 1'b1;
    tick();
    append = 1'b0;
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_mid_busy", busy, 0);
    chk("clr_mid_len", length, 0);
    chk("clr_mid_done", append_done, 0);
    tick();
    chk("clr_mid_done2", append_done, 0);
    chk("clr_mid_busy2", busy, 0);

    // Asynchronous reset while stuck resampling.
    app_ok(4'h1, 1);
    app_ok(4'h1, 2);
    rnd = 4'h1; append = 1'b1;
    tick();
    append = 1'b0;
    tick();
    chk("pre_rst_busy", busy, 1);
    reset = 1'b0;
    #2;
    chk("arst_busy", busy, 0);
    chk("arst_len", length, 0);
    chk("arst_done", append_done, 0);
    chk("arst_rd", rd_data, 0);
    reset = 1'b1;
    tick();
    chk("arst_after_busy", busy, 0);
    chk("arst_after_done", append_done, 0);
    chk("arst_after_len", length, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
